// File: rtl/m_pcpi_initiator_if.sv
// m_pcpi_initiator_if: command, PCPI and response bundles of the initiator.
// master is the initiator side, slave the environment side.
interface m_pcpi_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_insn;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        rsp_trap;

  modport master (
    input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
    input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy,
    input  rsp_ready,
    output cmd_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output rsp_valid, rsp_wr, rsp_rd, rsp_trap
  );

  modport slave (
    output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
    output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy,
    output rsp_ready,
    input  cmd_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  rsp_valid, rsp_wr, rsp_rd, rsp_trap
  );
endinterface

// File: rtl/m_pcpi_initiator.sv
// m_pcpi_initiator: issues one PCPI request at a time and returns its result.
// Define M_PCPI_TIMEOUT_EN to trap requests that no coprocessor claims.
module m_pcpi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  m_pcpi_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_insn;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_rd;
  logic        r_wr;
  logic        w_cmd_fire;
  logic        w_done;
  logic        w_expire;

  assign w_cmd_fire = (r_state == IDLE) && bus.cmd_valid;
  assign w_done     = ((r_state == ISSUE) || (r_state == WAIT))
                      && bus.pcpi_ready;

`ifdef M_PCPI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_trap;

  // Only a silent ISSUE cycle can expire; ready or busy win.
  assign w_expire = (r_state == ISSUE) && !bus.pcpi_ready
                    && !bus.pcpi_busy
                    && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_trap <= 1'b0;
    end else begin
      if (r_state == ISSUE && !w_expire) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state != ISSUE) begin
        r_cnt <= '0;
      end
      if (w_done) begin
        r_trap <= 1'b0;
      end else if (w_expire) begin
        r_trap <= 1'b1;
      end
    end
  end

  assign bus.rsp_trap = r_trap;
`else
  assign w_expire     = 1'b0;
  assign bus.rsp_trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.cmd_valid) w_next = ISSUE;
      end
      ISSUE: begin
        if (bus.pcpi_ready) w_next = RESP;
        else if (bus.pcpi_busy) w_next = WAIT;
        else if (w_expire) w_next = RESP;
      end
      WAIT: begin
        if (bus.pcpi_ready) w_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands stay put until the next command; the coprocessor reads them live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_insn <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_wr   <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_insn <= bus.cmd_insn;
        r_rs1  <= bus.cmd_rs1;
        r_rs2  <= bus.cmd_rs2;
      end
      if (w_done) begin
        r_wr <= bus.pcpi_wr;
        r_rd <= bus.pcpi_rd;
      end else if (w_expire) begin
        r_wr <= 1'b0;
        r_rd <= '0;
      end
    end
  end

  assign bus.cmd_ready  = (r_state == IDLE);
  assign bus.pcpi_valid = (r_state == ISSUE) || (r_state == WAIT);
  assign bus.pcpi_insn  = r_insn;
  assign bus.pcpi_rs1   = r_rs1;
  assign bus.pcpi_rs2   = r_rs2;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_wr     = r_wr;
  assign bus.rsp_rd     = r_rd;

endmodule
